// File: rtl/spi_arb_pkg.sv
// spi_arb_pkg: shared types and widths for the SPI bus arbiter.
package spi_arb_pkg;

    localparam int CS_IDX_W    = 7;
    localparam int DATA_W      = 8;
    localparam int NUM_REQ_DEF = 4;

    typedef enum logic [2:0] {
        IDLE,
        WAIT_BYTE,
        WB_WRITE,
        RETRY,
        RELEASE
    } arb_state_t;

endpackage

// File: rtl/spi_bus_arbiter_if.sv
// spi_bus_arbiter_if: requester bundle plus Wishbone master port.
interface spi_bus_arbiter_if
    import spi_arb_pkg::*;
#(
    parameter int NUM_REQ = NUM_REQ_DEF
);

    logic [NUM_REQ-1:0]          req_i;
    logic [NUM_REQ*CS_IDX_W-1:0] cs_idx_i;
    logic [NUM_REQ-1:0]          tx_valid_i;
    logic [NUM_REQ-1:0]          last_i;
    logic [NUM_REQ*DATA_W-1:0]   tx_data_i;
    logic [NUM_REQ-1:0]          grant_o;
    logic [NUM_REQ-1:0]          tx_ready_o;
    logic [NUM_REQ-1:0]          rx_valid_o;
    logic [DATA_W-1:0]           rx_data_o;
    logic [NUM_REQ-1:0]          done_o;
    logic [NUM_REQ-1:0]          err_o;
    logic                        STB_O;
    logic                        WE_O;
    logic [7:0]                  ADR_O;
    logic [DATA_W-1:0]           DAT_O;
    logic [DATA_W-1:0]           DAT_I;
    logic                        ACK_I;
    logic                        RTY_I;

    modport master (
        input  req_i, cs_idx_i, tx_valid_i, last_i, tx_data_i,
        input  DAT_I, ACK_I, RTY_I,
        output grant_o, tx_ready_o, rx_valid_o, rx_data_o,
        output done_o, err_o,
        output STB_O, WE_O, ADR_O, DAT_O
    );

    modport slave (
        output req_i, cs_idx_i, tx_valid_i, last_i, tx_data_i,
        output DAT_I, ACK_I, RTY_I,
        input  grant_o, tx_ready_o, rx_valid_o, rx_data_o,
        input  done_o, err_o,
        input  STB_O, WE_O, ADR_O, DAT_O
    );

endinterface

// File: rtl/spi_rr_picker.sv
// spi_rr_picker: one-hot round-robin winner, searching from last owner + 1.
module spi_rr_picker
    import spi_arb_pkg::*;
#(
    parameter int NUM_REQ = NUM_REQ_DEF
) (
    input  logic [NUM_REQ-1:0]         i_req,
    input  logic [$clog2(NUM_REQ)-1:0] i_last,
    output logic [NUM_REQ-1:0]         o_win
);

    localparam int IW = $clog2(NUM_REQ);

    logic [IW-1:0] w_idx;
    logic          w_found;

    always_comb begin
        o_win   = '0;
        w_found = 1'b0;
        w_idx   = '0;
        for (int k = 1; k <= NUM_REQ; k++) begin
            w_idx = IW'((int'(i_last) + k) % NUM_REQ);
            if (!w_found && i_req[w_idx]) begin
                o_win[w_idx] = 1'b1;
                w_found      = 1'b1;
            end
        end
    end

endmodule

// File: rtl/spi_bus_arbiter.sv
// spi_bus_arbiter: round-robin owner of one Wishbone-attached SPI master.
// Define SPI_ARB_TIMEOUT_EN to abort a byte whose ACK_I never arrives.
module spi_bus_arbiter
    import spi_arb_pkg::*;
#(
    parameter int NUM_REQ        = NUM_REQ_DEF,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic CLK_I,
    input  logic RST_I,
    spi_bus_arbiter_if.master bus
);

    localparam int IW = $clog2(NUM_REQ);

    arb_state_t          r_state;
    logic [NUM_REQ-1:0]  r_grant;
    logic [NUM_REQ-1:0]  r_tx_ready;
    logic [NUM_REQ-1:0]  r_rx_valid;
    logic [NUM_REQ-1:0]  r_done;
    logic [IW-1:0]       r_owner;
    logic [IW-1:0]       r_last_owner;
    logic [7:0]          r_adr;
    logic [DATA_W-1:0]   r_dat;
    logic [DATA_W-1:0]   r_rx_data;
    logic                r_stb;
    logic                r_we;
    logic                r_last;

    logic [NUM_REQ-1:0]  w_win;
    logic [IW-1:0]       w_win_idx;
    logic [CS_IDX_W-1:0] w_cs;
    logic [DATA_W-1:0]   w_tx_data;
    logic                w_req_g;
    logic                w_valid_g;
    logic                w_last_g;

`ifdef SPI_ARB_TIMEOUT_EN
    localparam logic [7:0] TMO_LAST = 8'(TIMEOUT_CYCLES - 1);
    logic [7:0]          r_tmo_cnt;
    logic [NUM_REQ-1:0]  r_err;
`endif

    spi_rr_picker #(
        .NUM_REQ (NUM_REQ)
    ) u_picker (
        .i_req  (bus.req_i),
        .i_last (r_last_owner),
        .o_win  (w_win)
    );

    always_comb begin
        w_win_idx = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (w_win[i]) w_win_idx = IW'(i);
        end
    end

    assign w_cs      = bus.cs_idx_i[w_win_idx*CS_IDX_W +: CS_IDX_W];
    assign w_req_g   = bus.req_i[r_owner];
    assign w_valid_g = bus.tx_valid_i[r_owner];
    assign w_last_g  = bus.last_i[r_owner];
    assign w_tx_data = bus.tx_data_i[r_owner*DATA_W +: DATA_W];

    always_ff @(posedge CLK_I) begin
        if (RST_I) begin
            r_state      <= IDLE;
            r_grant      <= '0;
            r_tx_ready   <= '0;
            r_rx_valid   <= '0;
            r_done       <= '0;
            r_owner      <= '0;
            r_last_owner <= IW'(NUM_REQ - 1);
            r_adr        <= '0;
            r_dat        <= '0;
            r_rx_data    <= '0;
            r_stb        <= 1'b0;
            r_we         <= 1'b0;
            r_last       <= 1'b0;
`ifdef SPI_ARB_TIMEOUT_EN
            r_tmo_cnt    <= '0;
            r_err        <= '0;
`endif
        end else begin
            r_rx_valid <= '0;
            r_done     <= '0;
`ifdef SPI_ARB_TIMEOUT_EN
            r_err      <= '0;
`endif
            unique case (r_state)
                IDLE: begin
                    if (|bus.req_i) begin
                        r_grant    <= w_win;
                        r_tx_ready <= w_win;
                        r_owner    <= w_win_idx;
                        r_adr      <= {1'b0, w_cs};
                        r_state    <= WAIT_BYTE;
                    end
                end
                WAIT_BYTE: begin
                    // a dropped request is an abort, not a completion
                    if (!w_req_g) begin
                        r_tx_ready <= '0;
                        r_state    <= RELEASE;
                    end else if (w_valid_g) begin
                        r_tx_ready <= '0;
                        r_dat      <= w_tx_data;
                        r_last     <= w_last_g;
                        r_stb      <= 1'b1;
                        r_we       <= 1'b1;
                        r_state    <= WB_WRITE;
`ifdef SPI_ARB_TIMEOUT_EN
                        r_tmo_cnt  <= '0;
`endif
                    end
                end
                WB_WRITE: begin
                    if (bus.ACK_I) begin
                        r_stb      <= 1'b0;
                        r_we       <= 1'b0;
                        r_rx_data  <= bus.DAT_I;
                        r_rx_valid <= r_grant;
                        if (r_last) begin
                            r_done  <= r_grant;
                            r_state <= RELEASE;
                        end else begin
                            r_tx_ready <= r_grant;
                            r_state    <= WAIT_BYTE;
                        end
                    end else if (bus.RTY_I) begin
                        r_stb   <= 1'b0;
                        r_we    <= 1'b0;
                        r_state <= RETRY;
                    end
`ifdef SPI_ARB_TIMEOUT_EN
                    else if (r_tmo_cnt == TMO_LAST) begin
                        r_stb   <= 1'b0;
                        r_we    <= 1'b0;
                        r_err   <= r_grant;
                        r_state <= RELEASE;
                    end else begin
                        r_tmo_cnt <= r_tmo_cnt + 8'd1;
                    end
`endif
                end
                RETRY: begin
                    r_stb     <= 1'b1;
                    r_we      <= 1'b1;
                    r_state   <= WB_WRITE;
`ifdef SPI_ARB_TIMEOUT_EN
                    r_tmo_cnt <= '0;
`endif
                end
                RELEASE: begin
                    r_grant      <= '0;
                    r_tx_ready   <= '0;
                    r_last_owner <= r_owner;
                    r_state      <= IDLE;
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign bus.grant_o    = r_grant;
    assign bus.tx_ready_o = r_tx_ready;
    assign bus.rx_valid_o = r_rx_valid;
    assign bus.rx_data_o  = r_rx_data;
    assign bus.done_o     = r_done;
    assign bus.STB_O      = r_stb;
    assign bus.WE_O       = r_we;
    assign bus.ADR_O      = r_adr;
    assign bus.DAT_O      = r_dat;
`ifdef SPI_ARB_TIMEOUT_EN
    assign bus.err_o      = r_err;
`else
    assign bus.err_o      = '0;
`endif

endmodule

// File: doc/spi_bus_arbiter.md
SPI_BUS_ARBITER -- requirements
Module: spi_bus_arbiter

Interface
REQ-001 Parameter NUM_REQ, default 4, number of requesters sharing one SPI master (range 2..8).
REQ-002 Parameter TIMEOUT_CYCLES, default 255, maximum ACK_I wait per byte when SPI_ARB_TIMEOUT_EN is defined.
REQ-003 CLK_I  in  1  single clock; one clock, reset is synchronous and active-high.
REQ-004 RST_I  in  1  reset; synchronous, active-high.
REQ-005 req_i  in  NUM_REQ  per-requester transaction request; level, held for the whole transaction.
REQ-006 cs_idx_i  in  NUM_REQ*7  per-requester chip-select index (0..127).
REQ-007 tx_valid_i / last_i  in  NUM_REQ each  byte valid; last_i marks final byte.
REQ-008 tx_data_i  in  NUM_REQ*8  per-requester byte to send.
REQ-009 grant_o  out  NUM_REQ  one-hot or zero; owner of the SPI master.
REQ-010 tx_ready_o  out  NUM_REQ  byte accept; only ever set for the granted index.
REQ-011 rx_valid_o  out  NUM_REQ  one-cycle pulse to owner; rx_data_o  out  8  received byte (shared).
REQ-012 done_o / err_o  out  NUM_REQ each  one-cycle completion / timeout-abort pulse to owner.
REQ-013 STB_O, WE_O  out  1 each; ADR_O  out  8 ({1'b0, cs_idx}); DAT_O  out  8; DAT_I  in  8; ACK_I, RTY_I  in  1 each; Wishbone master port to the SPI master.

Function
REQ-014 States: IDLE, WAIT_BYTE, WB_WRITE, RETRY, RELEASE.
REQ-015 IDLE: any req_i set -> pick winner round-robin, starting at the index after the last owner; after reset, index 0 has priority.
REQ-016 Grant latency: grant_o one-hot on the cycle after the request is sampled in IDLE; cs_idx is latched at the same edge, and the state becomes WAIT_BYTE.
REQ-017 WAIT_BYTE: tx_ready_o[g]=1; on tx_valid_i[g]: latch tx_data and last_i, then go to WB_WRITE with STB_O=WE_O=1 on the next cycle.
REQ-018 WB_WRITE: hold STB_O, ADR_O, DAT_O stable until ACK_I or RTY_I.
REQ-019 On ACK_I: drop STB_O at the same edge, register DAT_I into rx_data_o, pulse rx_valid_o[g]; then go to RELEASE if the latched last is set, else WAIT_BYTE.
REQ-020 On RTY_I: drop STB_O for exactly one cycle (RETRY), then reissue the same byte; ACK_I and RTY_I together are treated as ACK_I.
REQ-021 RELEASE: pulse done_o[g] (normal end only), clear grant_o, store g as the last owner, return to IDLE; no grant is issued in the RELEASE cycle.
REQ-022 req_i[g] deasserted in WAIT_BYTE -> abort: RELEASE without done_o, err_o not pulsed.
REQ-023 req_i[g] deasserted in WB_WRITE is ignored until the byte completes, then behaves as REQ-022.
REQ-024 Requests from non-owners never preempt; they wait for IDLE.
REQ-025 Outputs to non-granted indices are always 0.

Reset
REQ-026 RST_I sets: state IDLE; grant_o, tx_ready_o, rx_valid_o, done_o, err_o, STB_O, WE_O = 0; ADR_O, DAT_O, rx_data_o = 0; last owner = NUM_REQ-1.
REQ-027 RST_I mid-transaction drops STB_O on the next edge with no done_o or err_o pulse.

Configuration
REQ-028 Macro SPI_ARB_TIMEOUT_EN defined: an 8-bit counter clears on entry to WB_WRITE and counts while waiting.
REQ-029 When that counter reaches TIMEOUT_CYCLES, STB_O drops, err_o[g] pulses, and the state goes to RELEASE with no done_o.
REQ-030 Macro SPI_ARB_TIMEOUT_EN undefined: no counter, WB_WRITE waits indefinitely, and err_o is tied to 0.

Structure
REQ-031 Package spi_arb_pkg holds the state enum, CS_IDX_W=7, DATA_W=8 and the default NUM_REQ.
REQ-032 Sub-module spi_rr_picker holds the round-robin selection: inputs req vector and last owner, output one-hot winner.

Verification
REQ-033 Single requester: reset, req_i[0]=1, cs_idx=5, 2 bytes 0xA5, 0x3C with last on the second.
  Required: grant_o=0001 one cycle after req; two STB_O cycles with ADR_O=0x05; rx_valid pulses carry DAT_I; done_o[0] pulses.
REQ-034 Contention: req_i=1111 held, 1-byte transactions.
  Required: grants in order 0, 1, 2, 3, 0, with one idle cycle between owners.
REQ-035 Retry: RTY_I on the first attempt, ACK_I on the second.
  Required: STB_O low for exactly one cycle; DAT_O unchanged; one rx_valid pulse.
REQ-036 Abort: req_i[2] drops in WAIT_BYTE.
  Required: grant clears; no done_o or err_o; the next requester is granted.
REQ-037 Timeout, SPI_ARB_TIMEOUT_EN defined: ACK_I never asserted.
  Required: err_o pulse 255 cycles after STB_O rises; STB_O=0.
REQ-038 Timeout, SPI_ARB_TIMEOUT_EN undefined: ACK_I never asserted.
  Required: STB_O stays high indefinitely.
REQ-039 Reset mid-byte: RST_I asserted while STB_O=1.
  Required: all outputs are 0 on the next cycle.
